// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment driver for the clock display: frame snapshots,
// BCD decode with '-' for invalid nibbles, colon-style decimal points and alert blink.
module seg_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] hour,
    input  logic [7:0] minute,
    input  logic [7:0] second,
    input  logic       alert,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);
    localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
    localparam logic [FW-1:0] FRM_ONE  = FW'(1);

    logic [PW-1:0] prescaler;
    logic [2:0]    idx;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [7:0]    snap_hour;
    logic [7:0]    snap_minute;
    logic [7:0]    snap_second;
    logic          snap_alert;

    logic          tick;
    logic          frame_wrap;
    logic [3:0]    nibble;
    logic [5:0]    an_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;

    assign tick       = (prescaler == PRE_LAST);
    assign frame_wrap = tick && (idx == 3'd5);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaler   <= '0;
            idx         <= 3'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            snap_hour   <= 8'h00;
            snap_minute <= 8'h00;
            snap_second <= 8'h00;
            snap_alert  <= 1'b0;
            an          <= 6'b111111;
            seg         <= 7'b1111111;
            dp          <= 1'b1;
        end else begin
            if (tick) begin
                prescaler <= '0;
                idx       <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                prescaler <= prescaler + PRE_ONE;
            end
            // Capture, frame count and blink toggle all land on the same edge,
            // so the next frame starts coherent from its first digit.
            if (frame_wrap) begin
                snap_hour   <= hour;
                snap_minute <= minute;
                snap_second <= second;
                snap_alert  <= alert;
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FRM_ONE;
                end
            end
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
        end
    end

    always_comb begin
        nibble  = 4'd0;
        an_nxt  = 6'b111111;
        dp_nxt  = 1'b1;
        seg_nxt = 7'b1111111;
        case (idx)
            3'd0: begin nibble = snap_second[3:0]; an_nxt = 6'b111110; end
            3'd1: begin nibble = snap_second[7:4]; an_nxt = 6'b111101; end
            3'd2: begin nibble = snap_minute[3:0]; an_nxt = 6'b111011; dp_nxt = 1'b0; end
            3'd3: begin nibble = snap_minute[7:4]; an_nxt = 6'b110111; end
            3'd4: begin nibble = snap_hour[3:0];   an_nxt = 6'b101111; dp_nxt = 1'b0; end
            3'd5: begin nibble = snap_hour[7:4];   an_nxt = 6'b011111; end
            default: begin nibble = 4'd0; an_nxt = 6'b111111; end
        endcase
        case (nibble)
            4'd0:    seg_nxt = 7'b0000001;
            4'd1:    seg_nxt = 7'b1001111;
            4'd2:    seg_nxt = 7'b0010010;
            4'd3:    seg_nxt = 7'b0000110;
            4'd4:    seg_nxt = 7'b1001100;
            4'd5:    seg_nxt = 7'b0100100;
            4'd6:    seg_nxt = 7'b0100000;
            4'd7:    seg_nxt = 7'b0001111;
            4'd8:    seg_nxt = 7'b0000000;
            4'd9:    seg_nxt = 7'b0000100;
            default: seg_nxt = 7'b1111110;
        endcase
        if (an_nxt == 6'b111111) begin
            seg_nxt = 7'b1111111;
            dp_nxt  = 1'b1;
        end
        if (snap_alert && blink_phase) begin
            an_nxt  = 6'b111111;
            seg_nxt = 7'b1111111;
            dp_nxt  = 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=4, BLINK_FRAMES=2 (24-cycle frames).
module tb_seg_scan;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic       alert;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    int vectors     = 0;
    int miscompares = 0;
    int n           = 0;

    localparam logic [6:0] S_0    = 7'b0000001;
    localparam logic [6:0] S_1    = 7'b1001111;
    localparam logic [6:0] S_2    = 7'b0010010;
    localparam logic [6:0] S_3    = 7'b0000110;
    localparam logic [6:0] S_4    = 7'b1001100;
    localparam logic [6:0] S_5    = 7'b0100100;
    localparam logic [6:0] S_6    = 7'b0100000;
    localparam logic [6:0] S_9    = 7'b0000100;
    localparam logic [6:0] S_DASH = 7'b1111110;
    localparam logic [6:0] S_OFF  = 7'b1111111;
    localparam logic [5:0] A_OFF  = 6'b111111;

    always #5 clk = ~clk;

    seg_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (
        .clk    (clk),
        .reset  (reset),
        .hour   (hour),
        .minute (minute),
        .second (second),
        .alert  (alert),
        .an     (an),
        .seg    (seg),
        .dp     (dp)
    );

    task automatic check(input string tag, input logic [5:0] ea, input logic [6:0] es, input logic ed);
        vectors++;
        assert ({an, seg, dp} === {ea, es, ed}) else begin
            miscompares++;
            $error("FAIL %s (cycle %0d): an/seg/dp observed %b/%b/%b expected %b/%b/%b",
                   tag, n, an, seg, dp, ea, es, ed);
        end
    endtask

    // n = number of rising edges since reset release; sample 1 time unit after the edge
    task automatic run_to(input int target);
        while (n < target) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Output after edge 24*f+4*i+1 is the first cycle of digit i in frame f
    task automatic slot(input int f, input int i, input string tag,
                        input logic [5:0] ea, input logic [6:0] es, input logic ed);
        run_to(24 * f + 4 * i + 1);
        check(tag, ea, es, ed);
    endtask

    task automatic reset_and_release();
        reset  = 1'b0;
        hour   = 8'($urandom);
        minute = 8'($urandom);
        second = 8'($urandom);
        alert  = 1'($urandom);
        repeat (2) @(negedge clk);
        #1;
        check("reset_hold", A_OFF, S_OFF, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        n     = 0;
    endtask

    initial begin
        reset  = 1'b0;
        hour   = 8'h00;
        minute = 8'h00;
        second = 8'h00;
        alert  = 1'b0;

        // Scenarios 1-4
        reset_and_release();
        hour   = 8'h12;
        minute = 8'h34;
        second = 8'h56;
        alert  = 1'b0;
        run_to(1); check("rel_d0_first", 6'b111110, S_0, 1'b1);
        run_to(4); check("rel_d0_last",  6'b111110, S_0, 1'b1);
        run_to(5); check("rel_d1_first", 6'b111101, S_0, 1'b1);
        run_to(9); check("rel_d2_zero",  6'b111011, S_0, 1'b0);
        slot(1, 0, "f1_sec_ones",  6'b111110, S_6, 1'b1);
        slot(1, 1, "f1_sec_tens",  6'b111101, S_5, 1'b1);
        slot(1, 2, "f1_min_ones",  6'b111011, S_4, 1'b0);
        slot(1, 3, "f1_min_tens",  6'b110111, S_3, 1'b1);
        slot(1, 4, "f1_hr_ones",   6'b101111, S_2, 1'b0);
        slot(1, 5, "f1_hr_tens",   6'b011111, S_1, 1'b1);
        run_to(48); check("f1_hr_tens_last", 6'b011111, S_1, 1'b1);
        slot(2, 0, "f2_sec_ones",  6'b111110, S_6, 1'b1);
        slot(2, 3, "f2_min_tens",  6'b110111, S_3, 1'b1);
        slot(3, 0, "f3_sec_ones",  6'b111110, S_6, 1'b1);
        run_to(78);
        minute = 8'h59;
        second = 8'h5F;
        slot(3, 2, "mid_min_ones_old", 6'b111011, S_4, 1'b0);
        slot(3, 3, "mid_min_tens_old", 6'b110111, S_3, 1'b1);
        slot(4, 0, "bad_bcd_dash",     6'b111110, S_DASH, 1'b1);
        slot(4, 1, "bad_bcd_tens",     6'b111101, S_5, 1'b1);
        slot(4, 2, "new_min_ones",     6'b111011, S_9, 1'b0);
        slot(4, 3, "new_min_tens",     6'b110111, S_5, 1'b1);

        // Scenario 5: alert blink, 2 frames on / 2 frames blank
        reset_and_release();
        hour   = 8'h12;
        minute = 8'h34;
        second = 8'h56;
        alert  = 1'b1;
        slot(1, 0, "blink_f1_on",    6'b111110, S_6, 1'b1);
        slot(2, 0, "blink_f2_off",   A_OFF, S_OFF, 1'b1);
        slot(2, 5, "blink_f2_off_d5", A_OFF, S_OFF, 1'b1);
        slot(3, 2, "blink_f3_off_dp", A_OFF, S_OFF, 1'b1);
        slot(4, 0, "blink_f4_on",    6'b111110, S_6, 1'b1);
        slot(4, 4, "blink_f4_on_d4", 6'b101111, S_2, 1'b0);
        slot(6, 0, "blink_f6_off",   A_OFF, S_OFF, 1'b1);
        run_to(150);
        alert = 1'b0;
        slot(6, 5, "alert_drop_same_frame", A_OFF, S_OFF, 1'b1);
        slot(7, 0, "alert_drop_next_frame", 6'b111110, S_6, 1'b1);

        // Scenario 6: asynchronous reset during digit 3
        slot(7, 3, "pre_reset_d3", 6'b110111, S_3, 1'b1);
        run_to(182);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", A_OFF, S_OFF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        n     = 0;
        run_to(1); check("rerel_d0", 6'b111110, S_0, 1'b1);
        run_to(5); check("rerel_d1", 6'b111101, S_0, 1'b1);
        slot(1, 0, "rerel_f1_d0", 6'b111110, S_6, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
